mkey_fifo_sync: RTL and testbench

- Clocked, parametrised keyboard scan-code FIFO; successor to the edge-clocked 8x8 keyboard ring buffer.
- Sits between the matrix-key scanner (writer) and the CPU keyboard port decode (reader).
- Adds single-clock operation, a show-ahead head word and a fill count.
- Adds a selectable full policy (drop newest / overwrite oldest) and a sticky overflow flag.
- Optional rise-edge detection lets level-type bus strobes be used as requests.

---
 rtl/mkey_pkg.sv | 18 +
 rtl/mkey_edge.sv | 28 ++
 rtl/mkey_fifo_sync.sv | 124 ++++++++++++
 tb/tb_mkey_fifo_sync.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mkey_pkg.sv
// Shared constants for the keyboard scan-code FIFO.
//   KEY_DW / KEY_AW : default data and address widths
//   depth()         : entry count for a given address width
//   POL_DROP / POL_OVERWRITE : full-policy encodings for the OVERWRITE parameter
package mkey_pkg;

   localparam int unsigned KEY_DW = 8;
   localparam int unsigned KEY_AW = 3;

   localparam int unsigned POL_DROP      = 0;
   localparam int unsigned POL_OVERWRITE = 1;

   // Number of entries addressed by an aw-bit pointer.
   function automatic int unsigned depth(input int unsigned aw);
      return 32'(1) << aw;
   endfunction

endpackage

// File: rtl/mkey_edge.sv
// 1-bit synchronous rise detector for request strobes.
//   clk, reset : clock and synchronous active-high reset
//   bypass     : 1 = pass req straight through (pulse-type requests)
//   req        : raw request input
//   take_c     : combinational qualified request
// The history register resets to 1 so a strobe already high at reset release is not taken.
module mkey_edge (
   input  logic clk,
   input  logic reset,
   input  logic bypass,
   input  logic req,
   output logic take_c
);

   logic req_q;
   logic req_d;

   always_comb begin
      req_d  = req;
      take_c = bypass ? req : (req & ~req_q);
   end

   always_ff @(posedge clk) begin
      if (reset) req_q <= 1'b1;
      else       req_q <= req_d;
   end

endmodule

// File: rtl/mkey_fifo_sync.sv
// Single-clock keyboard scan-code FIFO with show-ahead head word.
//   clk, reset : clock and synchronous active-high reset
//   wrreq/data : write request (level or pulse, see EDGE) and word to store
//   rdreq      : pop the head word
//   clr        : synchronous flush of pointers, count and overflow flag
//   kcode      : head word, zero when empty
//   kstrobe    : word available
//   bfull/bempty/count : fill state
//   ovf        : sticky flag, a word was dropped or overwritten
module mkey_fifo_sync
   import mkey_pkg::*;
#(
   parameter int unsigned DW        = KEY_DW,
   parameter int unsigned AW        = KEY_AW,
   parameter int unsigned OVERWRITE = POL_DROP,
   parameter int unsigned EDGE      = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wrreq,
   input  logic [DW-1:0] data,
   input  logic          rdreq,
   input  logic          clr,
   output logic [DW-1:0] kcode,
   output logic          kstrobe,
   output logic          bfull,
   output logic          bempty,
   output logic [AW:0]   count,
   output logic          ovf
);

   localparam int unsigned DEPTH = depth(AW);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          we_c, re_c, mem_we_c, full_c, rd_ok_c;

   // Request qualification (rise detect or bypass).
   mkey_edge u_wr_edge (
      .clk    (clk),
      .reset  (reset),
      .bypass (1'(EDGE == 0)),
      .req    (wrreq),
      .take_c (we_c)
   );

   mkey_edge u_rd_edge (
      .clk    (clk),
      .reset  (reset),
      .bypass (1'(EDGE == 0)),
      .req    (rdreq),
      .take_c (re_c)
   );

   // Next-state for pointers, count and overflow flag.
   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      mem_we_c = 1'b0;
      full_c   = (count_q == (AW+1)'(DEPTH));
      rd_ok_c  = re_c && (count_q != '0);

      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (we_c && rd_ok_c) begin
         // Simultaneous push/pop: occupancy and overflow flag are unchanged even when full.
         mem_we_c = 1'b1;
         wptr_d   = wptr_q + AW'(1);
         rptr_d   = rptr_q + AW'(1);
      end else if (we_c) begin
         if (!full_c) begin
            mem_we_c = 1'b1;
            wptr_d   = wptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
         end else if (OVERWRITE == POL_OVERWRITE) begin
            // Oldest word is discarded by moving the read pointer past it.
            mem_we_c = 1'b1;
            wptr_d   = wptr_q + AW'(1);
            rptr_d   = rptr_q + AW'(1);
            ovf_d    = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (rd_ok_c) begin
         rptr_d  = rptr_q + AW'(1);
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage array, contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[wptr_q] <= data;
   end

   assign kcode   = (count_q != '0) ? mem_q[rptr_q] : '0;
   assign kstrobe = (count_q != '0);
   assign bempty  = (count_q == '0);
   assign bfull   = (count_q == (AW+1)'(DEPTH));
   assign count   = count_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_mkey_fifo_sync.sv
module tb_mkey_fifo_sync;

   logic       clk = 1'b0;
   logic       reset, wrreq, rdreq, clr;
   logic [7:0] data;

   logic [7:0] kcode0, kcode1;
   logic       kstrobe0, kstrobe1, bfull0, bfull1, bempty0, bempty1, ovf0, ovf1;
   logic [3:0] count0, count1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mkey_fifo_sync #(.DW(8), .AW(3), .OVERWRITE(0), .EDGE(1)) u_drop (
      .clk(clk), .reset(reset), .wrreq(wrreq), .data(data), .rdreq(rdreq), .clr(clr),
      .kcode(kcode0), .kstrobe(kstrobe0), .bfull(bfull0), .bempty(bempty0),
      .count(count0), .ovf(ovf0)
   );

   mkey_fifo_sync #(.DW(8), .AW(3), .OVERWRITE(1), .EDGE(1)) u_ovw (
      .clk(clk), .reset(reset), .wrreq(wrreq), .data(data), .rdreq(rdreq), .clr(clr),
      .kcode(kcode1), .kstrobe(kstrobe1), .bfull(bfull1), .bempty(bempty1),
      .count(count1), .ovf(ovf1)
   );

   typedef struct {
      logic       wr;
      logic       rd;
      logic       cl;
      logic [7:0] d;
      int         cnt;
      int         kc;
      int         ov;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Full output check of both instances.
   task automatic chk_all(input string name, input int cnt, input int k0, input int k1,
                          input int o0, input int o1);
      chk({name, " count0"}, int'(count0), cnt);
      chk({name, " count1"}, int'(count1), cnt);
      chk({name, " kcode0"}, int'(kcode0), k0);
      chk({name, " kcode1"}, int'(kcode1), k1);
      chk({name, " ovf0"}, int'(ovf0), o0);
      chk({name, " ovf1"}, int'(ovf1), o1);
      chk({name, " bempty0"}, int'(bempty0), int'(cnt == 0));
      chk({name, " bempty1"}, int'(bempty1), int'(cnt == 0));
      chk({name, " kstrobe0"}, int'(kstrobe0), int'(cnt != 0));
      chk({name, " kstrobe1"}, int'(kstrobe1), int'(cnt != 0));
      chk({name, " bfull0"}, int'(bfull0), int'(cnt == 8));
      chk({name, " bfull1"}, int'(bfull1), int'(cnt == 8));
   endtask

   task automatic cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
      @(negedge clk);
      wrreq = w; rdreq = r; clr = c; data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_pulse(input logic [7:0] d);
      cycle(1'b1, 1'b0, 1'b0, d);
      cycle(1'b0, 1'b0, 1'b0, d);
   endtask

   task automatic rd_pulse();
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; wrreq = 1'b0; rdreq = 1'b0; clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic fill8();
      for (int i = 1; i <= 8; i++) wr_pulse(8'(i));
   endtask

   initial begin
      //            wr    rd    clr   data    cnt kc     ov
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h41, 1, 'h41, 0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h41, 1, 'h41, 0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h41, 1, 'h41, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 'h41, 0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h42, 2, 'h41, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 2, 'h41, 0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h43, 3, 'h41, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3, 'h41, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 'h42, 0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 'h42, 0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 2, 'h42, 0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 'h43, 0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 'h43, 0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 'h00, 0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 'h00, 0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 'h00, 0};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 'h00, 0};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h33, 1, 'h33, 0};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 'h33, 0};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 'h00, 0};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 'h00, 0};

      reset = 1'b1; wrreq = 1'b0; rdreq = 1'b0; clr = 1'b0; data = 8'h00;
      do_reset();
      chk_all("reset", 0, 0, 0, 0, 0);

      // Basic level-strobe traffic, empty read, simultaneous rd/wr when empty.
      for (int i = 0; i < 21; i++) begin
         cycle(vecs[i].wr, vecs[i].rd, vecs[i].cl, vecs[i].d);
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].kc, vecs[i].kc, vecs[i].ov, vecs[i].ov);
      end

      // Overflow: drop newest vs overwrite oldest.
      do_reset();
      fill8();
      chk_all("full", 8, 'h01, 'h01, 0, 0);
      wr_pulse(8'h09);
      chk_all("overflow", 8, 'h01, 'h02, 1, 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drop_rd%0d", i), int'(kcode0), i + 1);
         chk($sformatf("ovw_rd%0d", i), int'(kcode1), i + 2);
         rd_pulse();
      end
      chk_all("drained", 0, 0, 0, 1, 1);

      // Simultaneous read and write while full.
      do_reset();
      fill8();
      cycle(1'b1, 1'b1, 1'b0, 8'h55);
      chk_all("full_rdwr", 8, 'h02, 'h02, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) rd_pulse();
      chk_all("full_rdwr_last", 1, 'h55, 'h55, 0, 0);
      rd_pulse();
      chk_all("full_rdwr_empty", 0, 0, 0, 0, 0);

      // Flush with ovf set and a coincident write; history must update during clr.
      do_reset();
      fill8();
      wr_pulse(8'h09);
      for (int i = 0; i < 3; i++) rd_pulse();
      chk_all("five_q", 5, 'h04, 'h05, 1, 1);
      cycle(1'b1, 1'b0, 1'b1, 8'hAA);
      chk_all("clr_wr", 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 8'hAA);
      chk_all("after_clr_held", 0, 0, 0, 0, 0);

      // wrreq held high across reset must not be taken.
      @(negedge clk);
      wrreq = 1'b1; data = 8'h66; reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_all("held_reset1", 0, 0, 0, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 8'h66);
      chk_all("held_reset2", 0, 0, 0, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      wr_pulse(8'h77);
      chk_all("post_reset_wr", 1, 'h77, 'h77, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
